tile_offset_ctrl: RTL and testbench

- Controller that owns the row/column offset tables and cursor for the tile-scramble puzzle display.
- Accepts move/rotate instructions over a valid/ready handshake and sequences table clears.
- Runs an LFSR-driven auto-shuffle.
- The GPU pixel path reads offsets combinationally by tile index and reads cursor and scramble state for highlighting.

---
 rtl/tile_offset_ctrl_if.sv | 37 +++
 rtl/tile_offset_ctrl.sv | 174 +++++++++++++++++
 tb/tb_tile_offset_ctrl.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/tile_offset_ctrl_if.sv
// Command, shuffle and pixel-read bundle for tile_offset_ctrl.
// Carries move_count when TILE_OFFSET_CTRL_MOVE_COUNT_EN is defined.
interface tile_offset_ctrl_if;
    logic        cmd_valid;
    logic [3:0]  cmd_code;
    logic        cmd_ready;
    logic        shuffle_start;
    logic [7:0]  shuffle_steps;
    logic [3:0]  rd_x_idx;
    logic [3:0]  rd_y_idx;
    logic [3:0]  col_offset;
    logic [3:0]  row_offset;
    logic [3:0]  cursor_x;
    logic [3:0]  cursor_y;
    logic        scramble;
    logic        busy;
    logic        solved;
`ifdef TILE_OFFSET_CTRL_MOVE_COUNT_EN
    logic [15:0] move_count;
`endif

    modport master (
        output cmd_valid, cmd_code, shuffle_start, shuffle_steps, rd_x_idx, rd_y_idx,
        input  cmd_ready, col_offset, row_offset, cursor_x, cursor_y, scramble, busy, solved
`ifdef TILE_OFFSET_CTRL_MOVE_COUNT_EN
        , input move_count
`endif
    );

    modport slave (
        input  cmd_valid, cmd_code, shuffle_start, shuffle_steps, rd_x_idx, rd_y_idx,
        output cmd_ready, col_offset, row_offset, cursor_x, cursor_y, scramble, busy, solved
`ifdef TILE_OFFSET_CTRL_MOVE_COUNT_EN
        , output move_count
`endif
    );
endinterface

// File: rtl/tile_offset_ctrl.sv
// Offset tables, cursor, table clear and LFSR auto-shuffle for the tile-scramble display.
// Optional rotate-move counter enabled by defining TILE_OFFSET_CTRL_MOVE_COUNT_EN.
module tile_offset_ctrl #(
    parameter int          GRID_MAX  = 15,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input logic          sysclk,
    input logic          rst_n,
    tile_offset_ctrl_if.slave bus
);
    localparam logic [3:0]  GMAX   = 4'(GRID_MAX);
    localparam int          NTILES = GRID_MAX + 1;
    localparam logic [15:0] SEED   = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

    typedef enum logic [1:0] {IDLE, CLEAR, SHUFFLE} state_t;

    state_t      state_q, state_d;
    logic [3:0]  rowOff_q [16];
    logic [3:0]  rowOff_d [16];
    logic [3:0]  colOff_q [16];
    logic [3:0]  colOff_d [16];
    logic [3:0]  cursorX_q, cursorX_d;
    logic [3:0]  cursorY_q, cursorY_d;
    logic        scramble_q, scramble_d;
    logic        solved_q, solved_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [7:0]  steps_q, steps_d;
    logic [3:0]  clrIdx_q, clrIdx_d;
`ifdef TILE_OFFSET_CTRL_MOVE_COUNT_EN
    logic [15:0] moveCount_q, moveCount_d;
`else
    // counter and its port are absent in this build
`endif

    logic        cmdReady;
    logic        cmdAccept;
    logic [15:0] lfsrStep;
    logic [3:0]  shufIdx;

    function automatic logic [3:0] wrapInc(input logic [3:0] v);
        return (v == GMAX) ? 4'd0 : v + 4'd1;
    endfunction

    function automatic logic [3:0] wrapDec(input logic [3:0] v);
        return (v == 4'd0) ? GMAX : v - 4'd1;
    endfunction

    assign cmdReady  = (state_q == IDLE) && !bus.shuffle_start;
    assign cmdAccept = bus.cmd_valid && cmdReady;
    assign lfsrStep  = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    assign shufIdx   = 4'(int'(lfsrStep[4:1]) % NTILES);

    always_comb begin
        state_d    = state_q;
        rowOff_d   = rowOff_q;
        colOff_d   = colOff_q;
        cursorX_d  = cursorX_q;
        cursorY_d  = cursorY_q;
        scramble_d = scramble_q;
        lfsr_d     = lfsr_q;
        steps_d    = steps_q;
        clrIdx_d   = clrIdx_q;
`ifdef TILE_OFFSET_CTRL_MOVE_COUNT_EN
        moveCount_d = moveCount_q;
`endif
        solved_d = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (rowOff_q[i] != 4'd0 || colOff_q[i] != 4'd0) solved_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (bus.shuffle_start) begin
                    if (bus.shuffle_steps != 8'd0) begin
                        steps_d    = bus.shuffle_steps;
                        scramble_d = 1'b1;
                        state_d    = SHUFFLE;
`ifdef TILE_OFFSET_CTRL_MOVE_COUNT_EN
                        moveCount_d = 16'd0;
`endif
                    end
                end else if (cmdAccept) begin
                    case (bus.cmd_code)
                        4'd1: if (scramble_q) colOff_d[cursorX_q] = wrapInc(colOff_q[cursorX_q]);
                              else            cursorY_d = wrapDec(cursorY_q);
                        4'd2: if (scramble_q) rowOff_d[cursorY_q] = wrapInc(rowOff_q[cursorY_q]);
                              else            cursorX_d = wrapInc(cursorX_q);
                        4'd3: if (scramble_q) rowOff_d[cursorY_q] = wrapDec(rowOff_q[cursorY_q]);
                              else            cursorX_d = wrapDec(cursorX_q);
                        4'd4: if (scramble_q) colOff_d[cursorX_q] = wrapDec(colOff_q[cursorX_q]);
                              else            cursorY_d = wrapInc(cursorY_q);
                        4'd5: scramble_d = ~scramble_q;
                        4'd6: begin
                            state_d  = CLEAR;
                            clrIdx_d = 4'd0;
                        end
                        default: ;
                    endcase
`ifdef TILE_OFFSET_CTRL_MOVE_COUNT_EN
                    if (bus.cmd_code == 4'd6)
                        moveCount_d = 16'd0;
                    else if (scramble_q && bus.cmd_code >= 4'd1 && bus.cmd_code <= 4'd4
                             && moveCount_q != 16'hFFFF)
                        moveCount_d = moveCount_q + 16'd1;
`endif
                end
            end
            CLEAR: begin
                rowOff_d[clrIdx_q] = 4'd0;
                colOff_d[clrIdx_q] = 4'd0;
                if (clrIdx_q == GMAX) state_d  = IDLE;
                else                  clrIdx_d = clrIdx_q + 4'd1;
            end
            SHUFFLE: begin
                // Rotation is taken from the freshly advanced LFSR value, not the held one
                lfsr_d = lfsrStep;
                if (lfsrStep[0])
                    rowOff_d[shufIdx] = lfsrStep[5] ? wrapDec(rowOff_q[shufIdx]) : wrapInc(rowOff_q[shufIdx]);
                else
                    colOff_d[shufIdx] = lfsrStep[5] ? wrapDec(colOff_q[shufIdx]) : wrapInc(colOff_q[shufIdx]);
                steps_d = steps_q - 8'd1;
                if (steps_q == 8'd1) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            for (int i = 0; i < 16; i++) begin
                rowOff_q[i] <= 4'd0;
                colOff_q[i] <= 4'd0;
            end
            cursorX_q  <= 4'd0;
            cursorY_q  <= 4'd0;
            scramble_q <= 1'b0;
            solved_q   <= 1'b1;
            lfsr_q     <= SEED;
            steps_q    <= 8'd0;
            clrIdx_q   <= 4'd0;
`ifdef TILE_OFFSET_CTRL_MOVE_COUNT_EN
            moveCount_q <= 16'd0;
`endif
        end else begin
            state_q    <= state_d;
            rowOff_q   <= rowOff_d;
            colOff_q   <= colOff_d;
            cursorX_q  <= cursorX_d;
            cursorY_q  <= cursorY_d;
            scramble_q <= scramble_d;
            solved_q   <= solved_d;
            lfsr_q     <= lfsr_d;
            steps_q    <= steps_d;
            clrIdx_q   <= clrIdx_d;
`ifdef TILE_OFFSET_CTRL_MOVE_COUNT_EN
            moveCount_q <= moveCount_d;
`endif
        end
    end

    // Entries above GRID_MAX are never written, so they read back as 0
    assign bus.col_offset = colOff_q[bus.rd_x_idx];
    assign bus.row_offset = rowOff_q[bus.rd_y_idx];
    assign bus.cmd_ready  = cmdReady;
    assign bus.cursor_x   = cursorX_q;
    assign bus.cursor_y   = cursorY_q;
    assign bus.scramble   = scramble_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.solved     = solved_q;
`ifdef TILE_OFFSET_CTRL_MOVE_COUNT_EN
    assign bus.move_count = moveCount_q;
`endif
endmodule

// File: tb/tb_tile_offset_ctrl.sv
// Directed, scoreboard-checked bench for tile_offset_ctrl (GRID_MAX=15, seed 16'hACE1).
module tb_tile_offset_ctrl;
    logic sysclk;
    logic rst_n;
    tile_offset_ctrl_if ifc ();

    tile_offset_ctrl #(.GRID_MAX(15), .LFSR_SEED(16'hACE1)) dut (
        .sysclk (sysclk),
        .rst_n  (rst_n),
        .bus    (ifc.slave)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t        sb[$];
    int          compared   = 0;
    int          mismatched = 0;

    int          mCol[16];
    int          mRow[16];
    int          mCx, mCy;
    logic        mScr;
    logic [15:0] mLfsr;

    task automatic step();
        @(posedge sysclk);
        #1;
    endtask

    task automatic pushExp(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic checkOutput(input logic [31:0] obs);
        exp_t e;
        compared++;
        if (sb.size() == 0) begin
            mismatched++;
            $error("[TB] FAIL scoreboard-empty: observed %0d required an expected entry", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                mismatched++;
                $error("[TB] FAIL %s: observed %0d required %0d", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 16; i++) begin
            mCol[i] = 0;
            mRow[i] = 0;
        end
        mCx = 0; mCy = 0; mScr = 1'b0; mLfsr = 16'hACE1;
    endtask

    task automatic modelCmd(input int code);
        case (code)
            1: if (mScr) mCol[mCx] = (mCol[mCx] + 1) % 16;  else mCy = (mCy + 15) % 16;
            2: if (mScr) mRow[mCy] = (mRow[mCy] + 1) % 16;  else mCx = (mCx + 1) % 16;
            3: if (mScr) mRow[mCy] = (mRow[mCy] + 15) % 16; else mCx = (mCx + 15) % 16;
            4: if (mScr) mCol[mCx] = (mCol[mCx] + 15) % 16; else mCy = (mCy + 1) % 16;
            5: mScr = ~mScr;
            6: for (int i = 0; i < 16; i++) begin mCol[i] = 0; mRow[i] = 0; end
            default: ;
        endcase
    endtask

    task automatic modelShuffle(input int n);
        int idx, delta;
        mScr = 1'b1;
        for (int k = 0; k < n; k++) begin
            mLfsr = (mLfsr >> 1) ^ (mLfsr[0] ? 16'hB400 : 16'h0000);
            idx   = int'(mLfsr[4:1]);
            delta = mLfsr[5] ? 15 : 1;
            if (mLfsr[0]) mRow[idx] = (mRow[idx] + delta) % 16;
            else          mCol[idx] = (mCol[idx] + delta) % 16;
        end
    endtask

    task automatic applyStimulus(input int code);
        ifc.cmd_valid = 1'b1;
        ifc.cmd_code  = 4'(code);
        step();
        ifc.cmd_valid = 1'b0;
        ifc.cmd_code  = 4'd0;
        modelCmd(code);
    endtask

    task automatic checkTables(input string tag);
        for (int i = 0; i < 16; i++) begin
            ifc.rd_x_idx = 4'(i);
            ifc.rd_y_idx = 4'(i);
            #1;
            pushExp($sformatf("%s col[%0d]", tag, i), mCol[i]);
            checkOutput(ifc.col_offset);
            pushExp($sformatf("%s row[%0d]", tag, i), mRow[i]);
            checkOutput(ifc.row_offset);
        end
    endtask

    task automatic countBusy(output int cycles, output logic readySeen);
        cycles    = 0;
        readySeen = 1'b0;
        for (int k = 0; k < 60 && ifc.busy === 1'b1; k++) begin
            cycles++;
            readySeen = readySeen | (ifc.cmd_ready !== 1'b0);
            step();
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int   cyc;
        logic rdy;

        rst_n = 1'b0;
        ifc.cmd_valid = 1'b0; ifc.cmd_code = 4'd0;
        ifc.shuffle_start = 1'b0; ifc.shuffle_steps = 8'd0;
        ifc.rd_x_idx = 4'd0; ifc.rd_y_idx = 4'd0;
        modelReset();
        step(); step();
        rst_n = 1'b1;

        pushExp("reset busy", 0);      checkOutput(ifc.busy);
        pushExp("reset solved", 1);    checkOutput(ifc.solved);
        pushExp("reset scramble", 0);  checkOutput(ifc.scramble);
        pushExp("reset cursor_x", 0);  checkOutput(ifc.cursor_x);
        pushExp("reset cmd_ready", 1); checkOutput(ifc.cmd_ready);

        $display("[TB] cursor wrap left");
        applyStimulus(3);
        pushExp("cmd3 cursor_x", 15); checkOutput(ifc.cursor_x);
        pushExp("cmd3 cursor_y", 0);  checkOutput(ifc.cursor_y);
        pushExp("cmd3 solved", 1);    checkOutput(ifc.solved);
        pushExp("cmd3 cmd_ready", 1); checkOutput(ifc.cmd_ready);

        $display("[TB] move cursor to (4,7) and rotate row 7");
        for (int k = 0; k < 5; k++) applyStimulus(2);
        for (int k = 0; k < 7; k++) applyStimulus(4);
        pushExp("walk cursor_x", 4); checkOutput(ifc.cursor_x);
        pushExp("walk cursor_y", 7); checkOutput(ifc.cursor_y);
        applyStimulus(5);
        applyStimulus(2);
        ifc.rd_y_idx = 4'd7; #1;
        pushExp("rot row_offset[7]", 1); checkOutput(ifc.row_offset);
        pushExp("rot cursor_x", 4);      checkOutput(ifc.cursor_x);
        pushExp("rot cursor_y", 7);      checkOutput(ifc.cursor_y);
        pushExp("rot solved lag", 1);    checkOutput(ifc.solved);
        step();
        pushExp("rot solved", 0);        checkOutput(ifc.solved);
        applyStimulus(3);
        pushExp("unrot row_offset[7]", 0); checkOutput(ifc.row_offset);
        pushExp("unrot solved lag", 0);    checkOutput(ifc.solved);
        step();
        pushExp("unrot solved", 1);        checkOutput(ifc.solved);

        $display("[TB] column offset wrap both ways");
        applyStimulus(5);
        for (int k = 0; k < 4; k++) applyStimulus(3);
        applyStimulus(5);
        ifc.rd_x_idx = 4'd0;
        applyStimulus(4);
        pushExp("col0 down wrap", 15); checkOutput(ifc.col_offset);
        applyStimulus(1);
        pushExp("col0 up wrap", 0);    checkOutput(ifc.col_offset);

        $display("[TB] shuffle with colliding command");
        applyStimulus(5);
        ifc.shuffle_start = 1'b1; ifc.shuffle_steps = 8'd5;
        ifc.cmd_valid = 1'b1; ifc.cmd_code = 4'd6;
        #1;
        pushExp("shuffle cmd_ready", 0); checkOutput(ifc.cmd_ready);
        step();
        ifc.shuffle_start = 1'b0; ifc.shuffle_steps = 8'd0;
        ifc.cmd_valid = 1'b0; ifc.cmd_code = 4'd0;
        modelShuffle(5);
        pushExp("shuffle scramble", 1); checkOutput(ifc.scramble);
        countBusy(cyc, rdy);
        pushExp("shuffle busy cycles", 5); checkOutput(cyc);
        pushExp("shuffle ready leak", 0);  checkOutput(rdy);
        checkTables("shuffle5");

        $display("[TB] clear tables");
        applyStimulus(6);
        countBusy(cyc, rdy);
        pushExp("clear busy cycles", 16); checkOutput(cyc);
        pushExp("clear ready leak", 0);   checkOutput(rdy);
        step();
        pushExp("clear solved", 1);   checkOutput(ifc.solved);
        pushExp("clear scramble", 1); checkOutput(ifc.scramble);
        pushExp("clear cursor_y", 7); checkOutput(ifc.cursor_y);
        checkTables("clear");

        $display("[TB] reset during shuffle");
        ifc.shuffle_start = 1'b1; ifc.shuffle_steps = 8'd10;
        step();
        ifc.shuffle_start = 1'b0; ifc.shuffle_steps = 8'd0;
        step(); step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        modelReset();
        pushExp("rst busy", 0);     checkOutput(ifc.busy);
        pushExp("rst scramble", 0); checkOutput(ifc.scramble);
        pushExp("rst cursor_y", 0); checkOutput(ifc.cursor_y);
        checkTables("rst");

        ifc.shuffle_start = 1'b1; ifc.shuffle_steps = 8'd10;
        step();
        ifc.shuffle_start = 1'b0; ifc.shuffle_steps = 8'd0;
        modelShuffle(10);
        countBusy(cyc, rdy);
        pushExp("reshuffle busy cycles", 10); checkOutput(cyc);
        checkTables("reshuffle10");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
